// File: rtl/vedic_mult_pipe_hs.sv
// vedic_mult_pipe_hs: three-stage pipelined Urdhva-Tiryagbhyam multiplier with valid/ready handshake,
// per-transaction signed/unsigned mode and a sideband tag.

module vedic_cell #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);
  logic [2*W-1:0] col;
  // vertical-and-crosswise: each output column sums the bit products whose indices add to k
  always_comb begin
    p_o = '0;
    col = '0;
    for (int k = 0; k < 2*W-1; k++) begin
      col = '0;
      for (int i = 0; i < W; i++)
        for (int j = 0; j < W; j++)
          if (i + j == k) col += (2*W)'(a_i[i] & b_i[j]);
      p_o += col << k;
    end
  end
endmodule

module vedic_mul #(
  parameter int W = 16
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);
  if (W <= 4) begin : g_cell
    vedic_cell #(.W(W)) u_cell (.a_i(a_i), .b_i(b_i), .p_o(p_o));
  end else begin : g_split
    localparam int H = W/2;
    logic [W-1:0] ll, lh, hl, hh;
    logic [W:0]   mid;
    vedic_mul #(.W(H)) u_ll (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(ll));
    vedic_mul #(.W(H)) u_lh (.a_i(a_i[H-1:0]), .b_i(b_i[W-1:H]), .p_o(lh));
    vedic_mul #(.W(H)) u_hl (.a_i(a_i[W-1:H]), .b_i(b_i[H-1:0]), .p_o(hl));
    vedic_mul #(.W(H)) u_hh (.a_i(a_i[W-1:H]), .b_i(b_i[W-1:H]), .p_o(hh));
    assign mid = {1'b0, lh} + {1'b0, hl};
    assign p_o = {hh, ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}};
  end
endmodule

module vedic_mult_pipe_hs #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int H = WIDTH/2;
  logic               en, acc;
  logic [WIDTH-1:0]   ll_d, lh_d, hl_d, hh_d, corr_d;
  logic [WIDTH:0]     mid_d;
  logic [3*H-1:0]     up_d;
  logic [2*WIDTH-1:0] p_d;
  logic               v1_q, sgn1_q, v2_q, sgn2_q;
  logic [WIDTH-1:0]   ll1_q, lh1_q, hl1_q, hh1_q, corr1_q, hh2_q, corr2_q;
  logic [TAG_W-1:0]   tag1_q, tag2_q;
  logic [WIDTH:0]     mid2_q;
  logic [H-1:0]       lo2_q, llh2_q;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;
  assign acc      = in_valid && in_ready;

  vedic_mul #(.W(H)) u_ll (.a_i(in_a[H-1:0]),     .b_i(in_b[H-1:0]),     .p_o(ll_d));
  vedic_mul #(.W(H)) u_lh (.a_i(in_a[H-1:0]),     .b_i(in_b[WIDTH-1:H]), .p_o(lh_d));
  vedic_mul #(.W(H)) u_hl (.a_i(in_a[WIDTH-1:H]), .b_i(in_b[H-1:0]),     .p_o(hl_d));
  vedic_mul #(.W(H)) u_hh (.a_i(in_a[WIDTH-1:H]), .b_i(in_b[WIDTH-1:H]), .p_o(hh_d));

  // only the low WIDTH bits of the correction survive the shift by WIDTH mod 2^(2*WIDTH)
  assign corr_d = (in_a[WIDTH-1] ? in_b : '0) + (in_b[WIDTH-1] ? in_a : '0);
  assign mid_d  = {1'b0, lh1_q} + {1'b0, hl1_q};
  assign up_d   = {hh2_q, {H{1'b0}}} + {{(H-1){1'b0}}, mid2_q} + {{(2*H){1'b0}}, llh2_q};
  assign p_d    = {up_d, lo2_q} - {corr2_q & {WIDTH{sgn2_q}}, {WIDTH{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      ll1_q     <= '0;
      lh1_q     <= '0;
      hl1_q     <= '0;
      hh1_q     <= '0;
      corr1_q   <= '0;
      sgn1_q    <= 1'b0;
      tag1_q    <= '0;
      v2_q      <= 1'b0;
      mid2_q    <= '0;
      lo2_q     <= '0;
      llh2_q    <= '0;
      hh2_q     <= '0;
      corr2_q   <= '0;
      sgn2_q    <= 1'b0;
      tag2_q    <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      out_tag   <= '0;
    end else if (en) begin
      v1_q <= acc;
      if (acc) begin
        ll1_q   <= ll_d;
        lh1_q   <= lh_d;
        hl1_q   <= hl_d;
        hh1_q   <= hh_d;
        corr1_q <= corr_d;
        sgn1_q  <= in_signed;
        tag1_q  <= in_tag;
      end
      v2_q      <= v1_q;
      mid2_q    <= mid_d;
      lo2_q     <= ll1_q[H-1:0];
      llh2_q    <= ll1_q[WIDTH-1:H];
      hh2_q     <= hh1_q;
      corr2_q   <= corr1_q;
      sgn2_q    <= sgn1_q;
      tag2_q    <= tag1_q;
      out_valid <= v2_q;
      out_p     <= p_d;
      out_tag   <= tag2_q;
    end
  end
endmodule
